dmem_responder: RTL

//  Data-memory responder serving the MEM-stage load/store interface of the pipelined datapath.

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Fixed-latency data-memory responder for the MEM stage.
//                Latches a load/store request, waits LATENCY cycles while
//                stalling the pipeline, then completes with a one-cycle
//                response. Misaligned, out-of-range and read+write requests
//                are reported through addr_err without touching state.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_stall,
    output logic        resp_valid,
    output logic        addr_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q,    wr_d;
    logic               err_q,   err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mem_we;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req;
    logic               req_err;

    assign req = mem_read | mem_write;

    // Error classification is done once, on the values being latched.
    assign req_err = (addr[1:0] != 2'b00)
                   | ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS))
                   | (mem_read & mem_write);

    // Next-state, request latching, access strobes and stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    idx_d     = addr[IDX_W+1:2];
                    wdata_d   = wdata;
                    wr_d      = mem_write;
                    err_d     = req_err;
                    cnt_d     = 4'(LATENCY - 1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (!err_q) begin
                        if (wr_q) mem_we  = 1'b1;
                        else      rdata_d = mem[idx_q];
                    end
                end
            end
            S_RESP: begin
                // The pipeline still shows the completed request here.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Word store; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    assign rdata      = rdata_q;
    assign resp_valid = (state_q == S_RESP);
    assign addr_err   = (state_q == S_RESP) & err_q;

endmodule
`default_nettype wire
